// File: rtl/add_join_pkg.sv
// Shared definitions for the N-input arithmetic stream join.
//   ADD_WRAP / ADD_FULL / ADD_SAT : overflow-handling modes
//   calc_ow   : output width for a given (N, W, MODE)
//   sign_ext  : sign-extend a W-bit operand to the accumulator width
//   sat_clamp : clamp a full-precision sum into the signed W-bit range
//   skid_state_t : occupancy states of the 2-entry output buffer
// Operand width W is limited to DAT_MAX bits by the helper signatures.
package add_join_pkg;

   localparam int ADD_WRAP = 0;
   localparam int ADD_FULL = 1;
   localparam int ADD_SAT  = 2;

   localparam int DAT_MAX = 64;
   // Accumulator width: DAT_MAX + log2(16) + 1 guard bit, rounded up.
   localparam int ACC_W   = 72;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'd0,
      SK_ONE   = 2'd1,
      SK_TWO   = 2'd2
   } skid_state_t;

   function automatic int calc_ow(input int n, input int w, input int mode);
      return (mode == ADD_FULL) ? w + $clog2(n) : w;
   endfunction

   function automatic logic signed [ACC_W-1:0] sign_ext(input logic [DAT_MAX-1:0] v,
                                                        input int w);
      logic signed [ACC_W-1:0] t;
      t = {{(ACC_W-DAT_MAX){1'b0}}, v};
      // Park the operand's sign bit in the MSB, then shift back arithmetically.
      t = t <<< (ACC_W - w);
      return t >>> (ACC_W - w);
   endfunction

   function automatic logic [DAT_MAX-1:0] sat_clamp(input logic signed [ACC_W-1:0] s,
                                                    input int w);
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      hi        = '0;
      hi[w-1]   = 1'b1;
      hi        = hi - ACC_W'(1);
      lo        = -hi - ACC_W'(1);
      if (s > hi) begin
         return DAT_MAX'(hi);
      end else if (s < lo) begin
         return DAT_MAX'(lo);
      end else begin
         return DAT_MAX'(s);
      end
   endfunction

endpackage

// File: rtl/add_skid2.sv
// Two-entry elastic buffer. Accepts one word per cycle while not full and
// presents the oldest word on out_dat. in_ready is registered, so there is no
// combinational path from out_ack back to the producer side.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_dat/in_req/in_ready : write side (push = in_req & in_ready)
//   out_dat/out_req/out_ack : read side (pop = out_req & out_ack)
//
// state    | meaning
// ---------+-----------------------------------------------
// SK_EMPTY | no words held, out_req low
// SK_ONE   | e0 valid; can push and pop in the same cycle
// SK_TWO   | e0 and e1 valid; in_ready low until a pop
module add_skid2
   import add_join_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [DW-1:0] in_dat,
   input  logic          in_req,
   output logic          in_ready,
   output logic [DW-1:0] out_dat,
   output logic          out_req,
   input  logic          out_ack
);

   skid_state_t   state_q, state_d;
   logic [DW-1:0] e0_q, e0_d;
   logic [DW-1:0] e1_q, e1_d;
   logic          rdy_q, rdy_d;
   logic          push, pop;

   assign push = in_req & rdy_q;
   assign pop  = (state_q != SK_EMPTY) & out_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SK_EMPTY;
         e0_q    <= '0;
         e1_q    <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      e0_d    = e0_q;
      e1_d    = e1_q;
      case (state_q)
         SK_EMPTY: begin
            if (push) begin
               e0_d    = in_dat;
               state_d = SK_ONE;
            end
         end
         SK_ONE: begin
            if (push && pop) begin
               e0_d = in_dat;
            end else if (push) begin
               e1_d    = in_dat;
               state_d = SK_TWO;
            end else if (pop) begin
               state_d = SK_EMPTY;
            end
         end
         SK_TWO: begin
            if (pop) begin
               e0_d    = e1_q;
               state_d = SK_ONE;
            end
         end
         default: state_d = SK_EMPTY;
      endcase
      // Held low through reset so no handshake completes until the first edge after release.
      rdy_d = (state_d != SK_TWO);
   end

   assign in_ready = rdy_q;
   assign out_req  = (state_q != SK_EMPTY);
   assign out_dat  = e0_q;

endmodule

// File: rtl/add_join_n.sv
// N-input arithmetic join: waits until every input stream requests, consumes
// all of them together and emits their sum through a 2-entry elastic buffer.
//   clk, reset_n     : clock, asynchronous active-low reset
//   t_dat [N*W]      : input operands, channel k at [k*W +: W]
//   t_req / t_ack [N]: per-channel handshake
//   i_0_dat [OW]     : sum output (wrap, full precision or saturated by MODE)
//   i_0_req / i_0_ack: output handshake
module add_join_n
   import add_join_pkg::*;
#(
   parameter int N    = 2,
   parameter int W    = 32,
   parameter int MODE = ADD_WRAP,
   localparam int OW  = calc_ow(N, W, MODE)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [N*W-1:0] t_dat,
   input  logic [N-1:0]   t_req,
   output logic [N-1:0]   t_ack,
   output logic [OW-1:0]  i_0_dat,
   output logic           i_0_req,
   input  logic           i_0_ack
);

   localparam int LG = $clog2(N);
   localparam int NP = 1 << LG;
   // Exact for any N operands, so saturation sees the true sum in every mode.
   localparam int SW = W + LG + 1;

   logic signed [SW-1:0]    acc [NP];
   logic signed [SW-1:0]    sum;
   logic signed [ACC_W-1:0] sum_x;
   logic [OW-1:0]           res;
   logic [N-1:0]            others;
   logic                    in_ready;
   logic                    all_req;

   // Pairwise reduction; unused leaves beyond N stay zero.
   always_comb begin
      for (int k = 0; k < NP; k++) begin
         acc[k] = '0;
      end
      for (int k = 0; k < N; k++) begin
         acc[k] = SW'(sign_ext(DAT_MAX'(t_dat[k*W +: W]), W));
      end
      for (int s = 1; s < NP; s = s * 2) begin
         for (int i = 0; i < NP; i = i + 2 * s) begin
            acc[i] = acc[i] + acc[i+s];
         end
      end
      sum = acc[0];
   end

   assign sum_x = ACC_W'(sum);

   always_comb begin
      res = OW'(sum);
      if (MODE == ADD_SAT) begin
         res = OW'(sat_clamp(sum_x, W));
      end
   end

   // A channel's ack only depends on the other channels, so a producer may
   // wait for ack before raising req without deadlocking the join.
   always_comb begin
      t_ack  = '0;
      others = t_req;
      for (int k = 0; k < N; k++) begin
         others    = t_req;
         others[k] = 1'b1;
         t_ack[k]  = in_ready & (&others);
      end
   end

   assign all_req = &t_req;

   add_skid2 #(
      .DW (OW)
   ) u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_dat   (res),
      .in_req   (all_req),
      .in_ready (in_ready),
      .out_dat  (i_0_dat),
      .out_req  (i_0_req),
      .out_ack  (i_0_ack)
   );

endmodule

// File: tb/tb_add_join_n.sv
module tb_add_join_n;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---- instance a: N=2 W=32 wrap (scoreboarded) ----
   logic [63:0] a_dat;
   logic [1:0]  a_req, a_tack;
   logic [31:0] a_out;
   logic        a_oreq, a_oack;

   add_join_n #(.N(2), .W(32), .MODE(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .t_dat(a_dat), .t_req(a_req), .t_ack(a_tack),
      .i_0_dat(a_out), .i_0_req(a_oreq), .i_0_ack(a_oack));

   // ---- instance b: N=3 W=8 wrap ----
   logic [23:0] b_dat;
   logic [2:0]  b_req, b_tack;
   logic [7:0]  b_out;
   logic        b_oreq, b_oack;

   add_join_n #(.N(3), .W(8), .MODE(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .t_dat(b_dat), .t_req(b_req), .t_ack(b_tack),
      .i_0_dat(b_out), .i_0_req(b_oreq), .i_0_ack(b_oack));

   // ---- instances c0/c1/c2: N=2 W=8, modes 0/1/2 sharing inputs ----
   logic [15:0] c_dat;
   logic [1:0]  c_req, c0_tack, c1_tack, c2_tack;
   logic [7:0]  c0_out, c2_out;
   logic [8:0]  c1_out;
   logic        c0_oreq, c1_oreq, c2_oreq, c_oack;

   add_join_n #(.N(2), .W(8), .MODE(0)) dut_c0 (
      .clk(clk), .reset_n(reset_n), .t_dat(c_dat), .t_req(c_req), .t_ack(c0_tack),
      .i_0_dat(c0_out), .i_0_req(c0_oreq), .i_0_ack(c_oack));
   add_join_n #(.N(2), .W(8), .MODE(1)) dut_c1 (
      .clk(clk), .reset_n(reset_n), .t_dat(c_dat), .t_req(c_req), .t_ack(c1_tack),
      .i_0_dat(c1_out), .i_0_req(c1_oreq), .i_0_ack(c_oack));
   add_join_n #(.N(2), .W(8), .MODE(2)) dut_c2 (
      .clk(clk), .reset_n(reset_n), .t_dat(c_dat), .t_req(c_req), .t_ack(c2_tack),
      .i_0_dat(c2_out), .i_0_req(c2_oreq), .i_0_ack(c_oack));

   // ---- instance d: N=4 W=16 full precision ----
   logic [63:0] d_dat;
   logic [3:0]  d_req, d_tack;
   logic [17:0] d_out;
   logic        d_oreq, d_oack;

   add_join_n #(.N(4), .W(16), .MODE(1)) dut_d (
      .clk(clk), .reset_n(reset_n), .t_dat(d_dat), .t_req(d_req), .t_ack(d_tack),
      .i_0_dat(d_out), .i_0_req(d_oreq), .i_0_ack(d_oack));

   // ---- scoreboard / reference model for instance a ----
   logic [31:0] sbq[$];
   int          cnt_m = 0;
   bit          rdy_m = 1'b0;
   bit          last_fire = 1'b0;
   bit          mon_en = 1'b0;
   int          n_in = 0;
   int          n_out = 0;

   always @(negedge clk) begin
      logic [1:0]  exp_tack;
      logic [31:0] e;
      bit          pop_m, fire_m;
      if (mon_en) begin
         exp_tack = {rdy_m & a_req[0], rdy_m & a_req[1]};
         chk("a_tack", a_tack, exp_tack);
         chk("a_oreq", a_oreq, cnt_m != 0);
         pop_m  = (cnt_m != 0) && a_oack;
         fire_m = rdy_m && (&a_req);
         if (pop_m) begin
            e = sbq.pop_front();
            chk("a_dat", a_out, e);
            n_out++;
         end
         if (fire_m) begin
            sbq.push_back(a_dat[31:0] + a_dat[63:32]);
            n_in++;
         end
         cnt_m     = cnt_m + int'(fire_m) - int'(pop_m);
         rdy_m     = (cnt_m != 2);
         last_fire = fire_m;
      end
   end

   // Channels holding an unconsumed request keep req and data; others take new values.
   task automatic drive_a(input logic [1:0] want);
      for (int k = 0; k < 2; k++) begin
         if (!(a_req[k] && !last_fire)) begin
            a_req[k]           = want[k];
            a_dat[k*32 +: 32]  = $urandom;
         end
      end
   endtask

   logic [7:0] cv0 [4] = '{8'hFF, 8'h7F, 8'h80, 8'hC0};
   logic [7:0] cv1 [4] = '{8'h02, 8'h01, 8'hFF, 8'hC0};
   logic [7:0] ce0 [4] = '{8'h01, 8'h80, 8'h7F, 8'h80};
   logic [8:0] ce1 [4] = '{9'h001, 9'h080, 9'h17F, 9'h180};
   logic [7:0] ce2 [4] = '{8'h01, 8'h7F, 8'h80, 8'h80};
   logic [63:0] dv [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF, 64'h8000_8000_8000_8000};
   logic [17:0] de [3] = '{18'h3FFFC, 18'h1FFFC, 18'h20000};

   initial begin
      int n0, o0;
      logic [1:0] want;
      reset_n = 1'b0;
      a_dat = '0; a_req = 2'b11; a_oack = 1'b0;
      b_dat = '0; b_req = '0; b_oack = 1'b1;
      c_dat = '0; c_req = '0; c_oack = 1'b1;
      d_dat = '0; d_req = '0; d_oack = 1'b1;
      #12;
      chk("rst_oreq", a_oreq, 0);
      chk("rst_tack", a_tack, 0);
      chk("rst_dat", a_out, 0);
      a_req = 2'b00;
      @(posedge clk); #3;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // single sum 5 + 7
      @(posedge clk); #1;
      a_dat = {32'd7, 32'd5}; a_req = 2'b11; a_oack = 1'b1;
      @(negedge clk);
      chk("a_fire_tack", a_tack, 2'b11);
      @(posedge clk); #1;
      a_req = 2'b00;
      chk("a_sum12", a_out, 32'd12);
      chk("a_sum12_req", a_oreq, 1);
      repeat (2) begin @(posedge clk); #1; end

      // backpressure: exactly two accepted
      a_oack = 1'b0;
      n0 = n_in;
      repeat (6) begin @(posedge clk); #1; drive_a(2'b11); end
      chk("bp_accept", n_in - n0, 2);
      chk("bp_tack_zero", a_tack, 0);
      a_oack = 1'b1;
      o0 = n_out;
      repeat (4) begin
         @(posedge clk); #1;
         chk("bp_b2b_req", a_oreq, 1);
         drive_a(2'b11);
      end
      chk("bp_drain_cnt", n_out - o0, 4);

      // random soak
      repeat (1000) begin
         @(posedge clk); #1;
         a_oack = 1'($urandom_range(0, 1));
         drive_a(2'($urandom));
      end
      // drain: finish any pending channel, then idle
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         a_oack = 1'b1;
         want = last_fire ? 2'b00 : ((a_req != 2'b00) ? 2'b11 : 2'b00);
         drive_a(want);
         if (a_req == 2'b00 && cnt_m == 0) break;
      end
      chk("soak_drained_req", a_req, 0);
      chk("soak_drained_cnt", cnt_m, 0);

      // reset while buffer holds two entries
      a_oack = 1'b0;
      repeat (4) begin @(posedge clk); #1; drive_a(2'b11); end
      chk("pre_rst_full", cnt_m, 2);
      @(negedge clk);
      mon_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_oreq", a_oreq, 0);
      chk("mid_rst_tack", a_tack, 0);
      chk("mid_rst_dat", a_out, 0);
      sbq.delete();
      cnt_m = 0; rdy_m = 1'b0; last_fire = 1'b0;
      a_req = 2'b00;
      @(posedge clk); #3;
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(posedge clk); #1;
      a_dat = {32'd100, 32'hFFFF_FFFF}; a_req = 2'b11; a_oack = 1'b1;
      @(posedge clk); #1;
      a_req = 2'b00;
      chk("post_rst_sum", a_out, 32'd99);
      chk("post_rst_req", a_oreq, 1);
      @(posedge clk); #1;
      chk("post_rst_no_stale", a_oreq, 0);

      // N=3 partial requests
      b_dat = {8'd30, 8'd20, 8'd10}; b_req = 3'b011;
      repeat (4) begin
         @(negedge clk);
         chk("b_tack_wait", b_tack, 3'b100);
         chk("b_no_out", b_oreq, 0);
      end
      @(posedge clk); #1;
      b_req = 3'b111;
      @(negedge clk);
      chk("b_tack_all", b_tack, 3'b111);
      @(posedge clk); #1;
      b_req = 3'b000;
      chk("b_sum", b_out, 8'd60);
      chk("b_out_req", b_oreq, 1);
      @(posedge clk); #1;
      chk("b_once", b_oreq, 0);

      // W=8 overflow modes
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         c_dat = {cv1[i], cv0[i]}; c_req = 2'b11;
         @(negedge clk);
         chk("c_tack", c0_tack, 2'b11);
         @(posedge clk); #1;
         c_req = 2'b00;
         chk("c_wrap", c0_out, ce0[i]);
         chk("c_full", c1_out, ce1[i]);
         chk("c_sat", c2_out, ce2[i]);
         chk("c_sat_req", c2_oreq, 1);
      end

      // N=4 W=16 full precision
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         d_dat = dv[i]; d_req = 4'hF;
         @(negedge clk);
         chk("d_tack", d_tack, 4'hF);
         @(posedge clk); #1;
         d_req = 4'h0;
         chk("d_sum", d_out, de[i]);
         chk("d_req", d_oreq, 1);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
